// File: rtl/if_fetch_unit.sv
// if_fetch_unit: RV32I instruction-fetch stage.
// Owns the PC and drives a single-outstanding request/response instruction
// memory port. Presents instF/PCF/PCPlus4F/validF to the IF/ID register,
// honours the decode stall, takes redirects from EX and squashes the stale
// response that a redirect leaves in flight.
// Optional build macro IF_PERF_CNT_EN adds fetch_cnt / bubble_cnt counters.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instF,
  output logic [31:0] PCF,
  output logic [31:0] PCPlus4F,
  output logic        validF
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] bubble_cnt
`endif
);

  typedef enum logic {
    S_REQ  = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic        kill_q, kill_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pcf_q, pcf_d;
  logic [31:0] pcp4_q, pcp4_d;

  logic        out_free;
  logic        handshake;
  logic        capture;
  logic        consume;
  logic [31:0] pc_plus4;
  logic [31:0] redirect_target;
  logic        redirect_pc_unused;

  // Low target bits are discarded: fetches are always word aligned.
  assign redirect_target    = {redirect_pc[31:2], 2'b00};
  assign redirect_pc_unused = ^redirect_pc[1:0];

  // The output slot is free when empty or when its content leaves this cycle.
  assign out_free  = !valid_q || !stall;
  assign handshake = (state_q == S_REQ) && imem_req && imem_ready;
  // A response is only kept if it is not stale and no redirect lands now.
  assign capture   = (state_q == S_WAIT) && imem_rvalid && !kill_q && !redirect;
  assign consume   = valid_q && !stall;
  assign pc_plus4  = pc_q + 32'd4;

  // FSM state register (state and the stale-response kill flag).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_REQ;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
    end
  end

  // FSM next-state logic; a redirect marks any still-in-flight request as stale.
  always_comb begin
    state_d = state_q;
    kill_d  = kill_q;
    case (state_q)
      S_REQ: begin
        if (handshake) begin
          state_d = S_WAIT;
          // Accepted request was for the old PC if a redirect arrives now.
          kill_d  = redirect;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          state_d = S_REQ;
          kill_d  = 1'b0;
        end else if (redirect) begin
          kill_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_REQ;
        kill_d  = 1'b0;
      end
    endcase
  end

  // FSM outputs: request only from REQ and only when the output slot is free.
  always_comb begin
    imem_req  = (state_q == S_REQ) && out_free;
    imem_addr = pc_q;
  end

  // PC and output-register next values; redirect beats capture beats consume.
  always_comb begin
    pc_d    = pc_q;
    valid_d = valid_q;
    inst_d  = inst_q;
    pcf_d   = pcf_q;
    pcp4_d  = pcp4_q;
    if (redirect) begin
      pc_d    = redirect_target;
      valid_d = 1'b0;
      inst_d  = NOP_INST;
    end else if (capture) begin
      pc_d    = pc_plus4;
      valid_d = 1'b1;
      inst_d  = imem_rdata;
      pcf_d   = pc_q;
      pcp4_d  = pc_plus4;
    end else if (consume) begin
      valid_d = 1'b0;
      inst_d  = NOP_INST;
    end
  end

  // PC and IF/ID-facing output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      inst_q  <= NOP_INST;
      pcf_q   <= 32'h0000_0000;
      pcp4_q  <= 32'h0000_0000;
    end else begin
      pc_q    <= pc_d;
      valid_q <= valid_d;
      inst_q  <= inst_d;
      pcf_q   <= pcf_d;
      pcp4_q  <= pcp4_d;
    end
  end

  assign instF    = inst_q;
  assign PCF      = pcf_q;
  assign PCPlus4F = pcp4_q;
  assign validF   = valid_q;

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] bubble_cnt_q;

  // Performance counters: kept fetches and cycles presenting a bubble downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q  <= 32'h0000_0000;
      bubble_cnt_q <= 32'h0000_0000;
    end else begin
      if (capture) begin
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
      if (!valid_q && !stall) begin
        bubble_cnt_q <= bubble_cnt_q + 32'd1;
      end
    end
  end

  assign fetch_cnt  = fetch_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed, table-driven bench for if_fetch_unit.
// Each record drives one clock cycle: request-side outputs are checked just
// before the edge, the registered IF outputs just after it.
`timescale 1ns/1ps
module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instF;
  logic [31:0] PCF;
  logic [31:0] PCPlus4F;
  logic        validF;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] bubble_cnt;
`endif

  if_fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instF       (instF),
    .PCF         (PCF),
    .PCPlus4F    (PCPlus4F),
    .validF      (validF)
`ifdef IF_PERF_CNT_EN
    ,
    .fetch_cnt   (fetch_cnt),
    .bubble_cnt  (bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] rpc;
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;
    logic        chk_comb;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_v;
    logic [31:0] exp_inst;
    logic [31:0] exp_pcf;
    logic [31:0] exp_p4;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference counters derived from the expected values in the table.
  logic        model_v_prev = 1'b0;
  int unsigned model_fetch  = 0;
  int unsigned model_bubble = 0;

  function automatic vec_t mk(input logic r, input logic st, input logic rd,
                              input logic [31:0] rpc, input logic rdy,
                              input logic rv, input logic [31:0] rdata,
                              input logic cc, input logic req,
                              input logic [31:0] addr, input logic v,
                              input logic [31:0] inst, input logic [31:0] pcf,
                              input logic [31:0] p4);
    vec_t t;
    t.rst = r;  t.stall = st; t.redirect = rd; t.rpc = rpc;
    t.ready = rdy; t.rvalid = rv; t.rdata = rdata;
    t.chk_comb = cc; t.exp_req = req; t.exp_addr = addr;
    t.exp_v = v; t.exp_inst = inst; t.exp_pcf = pcf; t.exp_p4 = p4;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t t, input string tag);
    @(negedge clk);
    rst         = t.rst;
    stall       = t.stall;
    redirect    = t.redirect;
    redirect_pc = t.rpc;
    imem_ready  = t.ready;
    imem_rvalid = t.rvalid;
    imem_rdata  = t.rdata;
    #1;
    if (t.chk_comb) begin
      chk({tag, ".imem_req"}, {31'b0, imem_req}, {31'b0, t.exp_req});
      chk({tag, ".imem_addr"}, imem_addr, t.exp_addr);
    end
    @(posedge clk);
    #1;
    chk({tag, ".validF"}, {31'b0, validF}, {31'b0, t.exp_v});
    chk({tag, ".instF"}, instF, t.exp_inst);
    chk({tag, ".PCF"}, PCF, t.exp_pcf);
    chk({tag, ".PCPlus4F"}, PCPlus4F, t.exp_p4);
    $display("%s rst=%0b stall=%0b redir=%0b rv=%0b -> validF=%0b instF=%08h PCF=%08h PCPlus4F=%08h",
             tag, t.rst, t.stall, t.redirect, t.rvalid, validF, instF, PCF, PCPlus4F);
    if (t.rst) begin
      model_fetch  = 0;
      model_bubble = 0;
    end else begin
      if (!model_v_prev && !t.stall) model_bubble++;
      if (t.exp_v && !(model_v_prev && t.stall)) model_fetch++;
    end
    model_v_prev = t.exp_v;
  endtask

  vec_t vecs[$];

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;

    //            rst st rd rpc           rdy rv rdata          cc req addr          v  inst           pcf           p4
    vecs.push_back(mk(1, 0, 0, 32'h0,       0, 0, 32'h0,        0, 0, 32'h0,       0, NOP,          32'h0,        32'h0));
    vecs.push_back(mk(1, 0, 0, 32'h0,       1, 0, 32'h0,        1, 1, 32'h0,       0, NOP,          32'h0,        32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0,       1, 0, 32'h0,        1, 1, 32'h0,       0, NOP,          32'h0,        32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0,       1, 1, 32'h00500093, 1, 0, 32'h0,       1, 32'h00500093, 32'h0,        32'h4));
    vecs.push_back(mk(0, 0, 0, 32'h0,       1, 0, 32'h0,        1, 1, 32'h4,       0, NOP,          32'h0,        32'h4));
    vecs.push_back(mk(0, 0, 0, 32'h0,       1, 1, 32'h00100113, 1, 0, 32'h4,       1, 32'h00100113, 32'h4,        32'h8));
    vecs.push_back(mk(0, 0, 0, 32'h0,       1, 0, 32'h0,        1, 1, 32'h8,       0, NOP,          32'h4,        32'h8));
    vecs.push_back(mk(0, 0, 0, 32'h0,       1, 1, 32'h00208193, 1, 0, 32'h8,       1, 32'h00208193, 32'h8,        32'hC));
    // stall hold for three cycles
    vecs.push_back(mk(0, 1, 0, 32'h0,       1, 0, 32'h0,        1, 0, 32'hC,       1, 32'h00208193, 32'h8,        32'hC));
    vecs.push_back(mk(0, 1, 0, 32'h0,       1, 0, 32'h0,        1, 0, 32'hC,       1, 32'h00208193, 32'h8,        32'hC));
    vecs.push_back(mk(0, 1, 0, 32'h0,       1, 0, 32'h0,        1, 0, 32'hC,       1, 32'h00208193, 32'h8,        32'hC));
    vecs.push_back(mk(0, 0, 0, 32'h0,       1, 0, 32'h0,        1, 1, 32'hC,       0, NOP,          32'h8,        32'hC));
    vecs.push_back(mk(0, 0, 0, 32'h0,       1, 1, 32'h00418213, 1, 0, 32'hC,       1, 32'h00418213, 32'hC,        32'h10));
    vecs.push_back(mk(0, 0, 0, 32'h0,       1, 0, 32'h0,        1, 1, 32'h10,      0, NOP,          32'hC,        32'h10));
    // redirect while WAIT, misaligned target, stale response dropped
    vecs.push_back(mk(0, 0, 1, 32'h103,     1, 0, 32'h0,        1, 0, 32'h10,      0, NOP,          32'hC,        32'h10));
    vecs.push_back(mk(0, 0, 0, 32'h0,       1, 1, 32'hDEADBEEF, 1, 0, 32'h100,     0, NOP,          32'hC,        32'h10));
    vecs.push_back(mk(0, 0, 0, 32'h0,       1, 0, 32'h0,        1, 1, 32'h100,     0, NOP,          32'hC,        32'h10));
    vecs.push_back(mk(0, 0, 0, 32'h0,       1, 1, 32'h00000513, 1, 0, 32'h100,     1, 32'h00000513, 32'h100,      32'h104));
    vecs.push_back(mk(0, 0, 0, 32'h0,       1, 0, 32'h0,        1, 1, 32'h104,     0, NOP,          32'h100,      32'h104));
    // redirect under stall in the same cycle as rvalid
    vecs.push_back(mk(0, 1, 1, 32'h40,      1, 1, 32'h12345678, 1, 0, 32'h104,     0, NOP,          32'h100,      32'h104));
    vecs.push_back(mk(0, 0, 0, 32'h0,       1, 0, 32'h0,        1, 1, 32'h40,      0, NOP,          32'h100,      32'h104));
    vecs.push_back(mk(0, 0, 0, 32'h0,       1, 1, 32'h00C00093, 1, 0, 32'h40,      1, 32'h00C00093, 32'h40,       32'h44));
    // redirect under stall with a valid instruction held in REQ
    vecs.push_back(mk(0, 1, 1, 32'h200,     1, 0, 32'h0,        1, 0, 32'h44,      0, NOP,          32'h40,       32'h44));
    vecs.push_back(mk(0, 1, 0, 32'h0,       1, 0, 32'h0,        1, 1, 32'h200,     0, NOP,          32'h40,       32'h44));
    vecs.push_back(mk(0, 0, 0, 32'h0,       1, 1, 32'h00100093, 1, 0, 32'h200,     1, 32'h00100093, 32'h200,      32'h204));
    // redirect in REQ with handshake completing: old-PC response must be killed
    vecs.push_back(mk(0, 0, 1, 32'h300,     1, 0, 32'h0,        1, 1, 32'h204,     0, NOP,          32'h200,      32'h204));
    vecs.push_back(mk(0, 0, 0, 32'h0,       1, 1, 32'hBAD00000, 1, 0, 32'h300,     0, NOP,          32'h200,      32'h204));
    vecs.push_back(mk(0, 0, 0, 32'h0,       0, 0, 32'h0,        1, 1, 32'h300,     0, NOP,          32'h200,      32'h204));
    vecs.push_back(mk(0, 0, 0, 32'h0,       1, 0, 32'h0,        1, 1, 32'h300,     0, NOP,          32'h200,      32'h204));
    vecs.push_back(mk(0, 0, 0, 32'h0,       1, 1, 32'h00200113, 1, 0, 32'h300,     1, 32'h00200113, 32'h300,      32'h304));
    // back-to-back redirects while WAIT: last wins, one response drained
    vecs.push_back(mk(0, 0, 0, 32'h0,       1, 0, 32'h0,        1, 1, 32'h304,     0, NOP,          32'h300,      32'h304));
    vecs.push_back(mk(0, 0, 1, 32'h500,     1, 0, 32'h0,        1, 0, 32'h304,     0, NOP,          32'h300,      32'h304));
    vecs.push_back(mk(0, 0, 1, 32'h600,     1, 0, 32'h0,        1, 0, 32'h500,     0, NOP,          32'h300,      32'h304));
    vecs.push_back(mk(0, 0, 0, 32'h0,       1, 1, 32'hBAD11111, 1, 0, 32'h600,     0, NOP,          32'h300,      32'h304));
    vecs.push_back(mk(0, 0, 0, 32'h0,       1, 0, 32'h0,        1, 1, 32'h600,     0, NOP,          32'h300,      32'h304));
    vecs.push_back(mk(0, 0, 0, 32'h0,       1, 1, 32'h00300193, 1, 0, 32'h600,     1, 32'h00300193, 32'h600,      32'h604));

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], $sformatf("v%0d", i));
    end

    // Wrap-around of the PC at the top of the address space.
    apply(mk(0, 0, 1, 32'hFFFFFFFC, 0, 0, 32'h0,        1, 1, 32'h604,      0, NOP,   32'h600,      32'h604), "wrap0");
    apply(mk(0, 0, 0, 32'h0,        1, 0, 32'h0,        1, 1, 32'hFFFFFFFC, 0, NOP,   32'h600,      32'h604), "wrap1");
    apply(mk(0, 0, 0, 32'h0,        1, 1, 32'h00000013, 1, 0, 32'hFFFFFFFC, 1, 32'h13, 32'hFFFFFFFC, 32'h0),  "wrap2");
    apply(mk(0, 0, 0, 32'h0,        1, 0, 32'h0,        1, 1, 32'h0,        0, NOP,   32'hFFFFFFFC, 32'h0),  "wrap3");

`ifdef IF_PERF_CNT_EN
    chk("fetch_cnt", fetch_cnt, model_fetch);
    chk("bubble_cnt", bubble_cnt, model_bubble);
`endif

    // Reset while a request is outstanding; a late rvalid in REQ is ignored.
    apply(mk(1, 0, 0, 32'h0,        0, 0, 32'h0,        1, 0, 32'h0,        0, NOP,   32'h0,        32'h0),  "mrst0");
    apply(mk(0, 0, 0, 32'h0,        0, 1, 32'hBAD22222, 1, 1, 32'h0,        0, NOP,   32'h0,        32'h0),  "mrst1");
    apply(mk(0, 0, 0, 32'h0,        1, 0, 32'h0,        1, 1, 32'h0,        0, NOP,   32'h0,        32'h0),  "mrst2");
    apply(mk(0, 0, 0, 32'h0,        1, 1, 32'h00500093, 1, 0, 32'h0,        1, 32'h00500093, 32'h0,  32'h4),  "mrst3");

`ifdef IF_PERF_CNT_EN
    chk("fetch_cnt_after_rst", fetch_cnt, model_fetch);
    chk("bubble_cnt_after_rst", bubble_cnt, model_bubble);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Guard against a stuck simulation.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
